imem_boot_loader: RTL

//  Boot sequencer for the single-cycle core's instruction memory. Holds the core in reset,

---
 rtl/imem_boot_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams a length/data/checksum byte frame
// into instruction memory from BASE_ADDR, and releases the core once the XOR checksum matches.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        imem_sel_o,
    output logic        imem_wr_en_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wr_data_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   shift_q, shift_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          imem_wr_en_q, imem_wr_en_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wr_data_q, imem_wr_data_d;
    logic          imem_sel_q, imem_sel_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic          word_done;
    logic [31:0]   word;

    // The write cycle of each data word is a one-cycle bubble on the byte stream.
    assign in_ready_o = (state_q == S_LEN) || (state_q == S_CSUM) ||
                        ((state_q == S_DATA) && !imem_wr_en_q);
    // A restart in the same cycle as a byte handshake drops that byte.
    assign accept     = in_valid_i && in_ready_o && !start_i;
    assign word_done  = accept && (lane_q == 2'd3);
    assign word       = {in_data_i, shift_q};

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        shift_d        = shift_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        imem_wr_en_d   = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wr_data_d = imem_wr_data_q;
        imem_sel_d     = imem_sel_q;
        cpu_rst_d      = cpu_rst_q;
        done_d         = done_q;
        err_d          = err_q;

        if (accept) begin
            shift_d = {in_data_i, shift_q[23:8]};
            lane_d  = lane_q + 2'd1;
        end

        if (start_i) begin
            state_d    = S_LEN;
            lane_d     = 2'd0;
            cnt_d      = '0;
            acc_d      = '0;
            imem_sel_d = 1'b1;
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (word_done) begin
                        if ((word == 32'd0) || (word > 32'(MAX_WORDS))) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d     = S_DATA;
                            len_d       = word[CW-1:0];
                            cnt_d       = '0;
                            acc_d       = '0;
                            imem_addr_d = BASE_ADDR;
                        end
                    end
                end
                S_DATA: begin
                    if (word_done) begin
                        imem_wr_en_d   = 1'b1;
                        imem_addr_d    = BASE_ADDR + (32'(cnt_q) << 2);
                        imem_wr_data_d = word;
                        acc_d          = acc_q ^ word;
                        cnt_d          = cnt_q + CW'(1);
                    end else if (imem_wr_en_q && (cnt_q == len_q)) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (word_done) begin
                        if (word == acc_q) begin
                            state_d    = S_RUN;
                            imem_sel_d = 1'b0;
                            cpu_rst_d  = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lane_q         <= 2'd0;
            shift_q        <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            imem_wr_en_q   <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wr_data_q <= '0;
            imem_sel_q     <= 1'b1;
            cpu_rst_q      <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            shift_q        <= shift_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            imem_wr_en_q   <= imem_wr_en_d;
            imem_addr_q    <= imem_addr_d;
            imem_wr_data_q <= imem_wr_data_d;
            imem_sel_q     <= imem_sel_d;
            cpu_rst_q      <= cpu_rst_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign imem_wr_en_o   = imem_wr_en_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_wr_data_o = imem_wr_data_q;
    assign imem_sel_o     = imem_sel_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule
